// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM port among N_REQ masters with round-robin ownership and read-data tagging.
// Optional owner-hold timeout is compiled in when SRAM_ARB_TIMEOUT_EN is defined.
module sram_port_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
`ifdef SRAM_ARB_TIMEOUT_EN
    ,
    parameter int MAX_HOLD = 1024
`endif
) (
    input  logic                      Clock,
    input  logic                      Resetn,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_address,
    input  logic [N_REQ*DATA_W-1:0]   req_write_data,
    input  logic [N_REQ-1:0]          req_we_n,
    output logic [N_REQ-1:0]          grant,
    output logic [ADDR_W-1:0]         SRAM_address,
    output logic [DATA_W-1:0]         SRAM_write_data,
    output logic                      SRAM_we_n,
    input  logic [DATA_W-1:0]         SRAM_read_data,
    output logic [DATA_W-1:0]         rdata,
    output logic [N_REQ-1:0]          rdata_valid
`ifdef SRAM_ARB_TIMEOUT_EN
    ,
    output logic                      timeout_pulse
`endif
);

    // state     | meaning
    // S_IDLE    | no owner; next edge grants first req at/after rr pointer
    // S_OWNED   | owner's address/data/we_n drive the SRAM
    // S_HANDOFF | single dead cycle between owners
    typedef enum logic [1:0] {S_IDLE, S_OWNED, S_HANDOFF} state_t;

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                owner_q, owner_d;
    logic [IDX_W-1:0]                rr_q, rr_d;
    logic [N_REQ-1:0]                grant_d;
    logic                            pick_found;
    logic [IDX_W-1:0]                pick_idx;
    logic [IDX_W:0]                  cand;
    logic                            owner_req;
    logic                            owner_we_n;
    logic                            rd_push;
    logic                            evict;
    logic [RD_LAT-1:0]               tag_v_q;
    logic [RD_LAT-1:0][IDX_W-1:0]    tag_id_q;

    // Rotating scan starting at the rr pointer, wrapping at N_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!pick_found && req[cand[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign owner_req  = req[owner_q];
    assign owner_we_n = req_we_n[owner_q];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        grant_d = grant;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d = S_OWNED;
                    owner_d = pick_idx;
                    grant_d = N_REQ'(1) << pick_idx;
                end
            end
            S_OWNED: begin
                if (!owner_req || evict) begin
                    state_d = S_HANDOFF;
                    grant_d = '0;
                    if (owner_q == IDX_W'(N_REQ-1)) begin
                        rr_d = '0;
                    end else begin
                        rr_d = owner_q + IDX_W'(1);
                    end
                end
            end
            S_HANDOFF: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        if (state_q == S_OWNED) begin
            SRAM_address    = req_address[int'(owner_q)*ADDR_W +: ADDR_W];
            SRAM_write_data = req_write_data[int'(owner_q)*DATA_W +: DATA_W];
            SRAM_we_n       = owner_we_n;
        end
    end

    assign rd_push = (state_q == S_OWNED) && owner_we_n;
    assign rdata   = SRAM_read_data;

    always_comb begin
        rdata_valid = '0;
        if (tag_v_q[RD_LAT-1]) begin
            rdata_valid = N_REQ'(1) << tag_id_q[RD_LAT-1];
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            rr_q     <= '0;
            grant    <= '0;
            tag_v_q  <= '0;
            tag_id_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            grant       <= grant_d;
            tag_v_q[0]  <= rd_push;
            tag_id_q[0] <= owner_q;
            for (int s = 1; s < RD_LAT; s++) begin
                tag_v_q[s]  <= tag_v_q[s-1];
                tag_id_q[s] <= tag_id_q[s-1];
            end
        end
    end

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_q;
    logic              others_req;

    // Down-counter reaches terminal count on the MAX_HOLD-th owned cycle and saturates there.
    assign others_req    = |(req & ~grant);
    assign evict         = (state_q == S_OWNED) && (hold_q == '0) && others_req;
    assign timeout_pulse = evict;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            hold_q <= '0;
        end else if (state_q != S_OWNED && state_d == S_OWNED) begin
            hold_q <= HOLD_W'(MAX_HOLD - 1);
        end else if (state_q == S_OWNED && hold_q != '0) begin
            hold_q <= hold_q - HOLD_W'(1);
        end
    end
`else
    assign evict = 1'b0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: vector table, directed reset/timeout sequences, randomized run against a reference model.
module tb_sram_port_arbiter;
    localparam int N     = 3;
    localparam int AW    = 18;
    localparam int DW    = 16;
    localparam int LAT   = 2;
    localparam int NRAND = 3000;
`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int MAX_HOLD = 8;
`endif
    localparam logic [AW-1:0] A0  = 18'd2577;
    localparam logic [AW-1:0] A2  = 18'd146944;
    localparam logic [DW-1:0] WD0 = 16'h1111;
    localparam logic [DW-1:0] WD1 = 16'h2222;
    localparam logic [DW-1:0] WD2 = 16'h3333;

    logic            Clock = 1'b0;
    logic            Resetn;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_address;
    logic [N*DW-1:0] req_write_data;
    logic [N-1:0]    req_we_n;
    logic [N-1:0]    grant;
    logic [AW-1:0]   SRAM_address;
    logic [DW-1:0]   SRAM_write_data;
    logic            SRAM_we_n;
    logic [DW-1:0]   SRAM_read_data;
    logic [DW-1:0]   rdata;
    logic [N-1:0]    rdata_valid;
`ifdef SRAM_ARB_TIMEOUT_EN
    logic            timeout_pulse;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clock = ~Clock;

    sram_port_arbiter #(
        .N_REQ(N),
        .ADDR_W(AW),
        .DATA_W(DW),
        .RD_LAT(LAT)
`ifdef SRAM_ARB_TIMEOUT_EN
        ,
        .MAX_HOLD(MAX_HOLD)
`endif
    ) dut (
        .Clock(Clock),
        .Resetn(Resetn),
        .req(req),
        .req_address(req_address),
        .req_write_data(req_write_data),
        .req_we_n(req_we_n),
        .grant(grant),
        .SRAM_address(SRAM_address),
        .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n(SRAM_we_n),
        .SRAM_read_data(SRAM_read_data),
        .rdata(rdata),
        .rdata_valid(rdata_valid)
`ifdef SRAM_ARB_TIMEOUT_EN
        ,
        .timeout_pulse(timeout_pulse)
`endif
    );

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          rst;
        logic [N-1:0]  rq;
        logic [N-1:0]  we;
        logic [AW-1:0] a1;
        logic [DW-1:0] rd;
        logic [N-1:0]  g;
        logic          swe;
        logic [AW-1:0] sa;
        logic [N-1:0]  rv;
    } vec_t;

    vec_t tbl [17];

    // reference model: owner index (-1 = none), one dead cycle flag, rotating priority,
    // and a calendar of which requester's read data is due in which cycle
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_dead;
    int cyc;
    int due [NRAND+LAT+2];

    initial begin
        logic [N-1:0]  exp_g;
        logic [N-1:0]  exp_rv;
        logic [AW-1:0] exp_a;
        logic [DW-1:0] exp_wd;
        logic          exp_we;
        logic          exp_to;
        bit            found;

        tbl[0]  = '{1'b0, 3'b111, 3'b111, 18'd38400, 16'h0001, 3'b000, 1'b1, 18'd0,     3'b000};
        tbl[1]  = '{1'b1, 3'b111, 3'b111, 18'd38400, 16'h0002, 3'b000, 1'b1, 18'd0,     3'b000};
        tbl[2]  = '{1'b1, 3'b111, 3'b111, 18'd38400, 16'h0003, 3'b001, 1'b1, A0,        3'b000};
        tbl[3]  = '{1'b1, 3'b110, 3'b111, 18'd38400, 16'h0004, 3'b001, 1'b1, A0,        3'b000};
        tbl[4]  = '{1'b1, 3'b110, 3'b111, 18'd38400, 16'h0005, 3'b000, 1'b1, 18'd0,     3'b001};
        tbl[5]  = '{1'b1, 3'b110, 3'b111, 18'd38400, 16'h0006, 3'b000, 1'b1, 18'd0,     3'b001};
        tbl[6]  = '{1'b1, 3'b110, 3'b011, 18'd38400, 16'h0007, 3'b010, 1'b1, 18'd38400, 3'b000};
        tbl[7]  = '{1'b1, 3'b110, 3'b011, 18'd38400, 16'hBEEF, 3'b010, 1'b1, 18'd38400, 3'b000};
        tbl[8]  = '{1'b1, 3'b110, 3'b001, 18'd38401, 16'h0009, 3'b010, 1'b0, 18'd38401, 3'b010};
        tbl[9]  = '{1'b1, 3'b100, 3'b011, 18'd38401, 16'h000A, 3'b010, 1'b1, 18'd38401, 3'b010};
        tbl[10] = '{1'b1, 3'b100, 3'b011, 18'd38401, 16'h000B, 3'b000, 1'b1, 18'd0,     3'b000};
        tbl[11] = '{1'b1, 3'b100, 3'b011, 18'd38401, 16'h000C, 3'b000, 1'b1, 18'd0,     3'b010};
        tbl[12] = '{1'b1, 3'b101, 3'b111, 18'd38401, 16'h000D, 3'b100, 1'b1, A2,        3'b000};
        tbl[13] = '{1'b1, 3'b001, 3'b111, 18'd38401, 16'h000E, 3'b100, 1'b1, A2,        3'b000};
        tbl[14] = '{1'b1, 3'b001, 3'b111, 18'd38401, 16'h000F, 3'b000, 1'b1, 18'd0,     3'b100};
        tbl[15] = '{1'b1, 3'b001, 3'b111, 18'd38401, 16'h0010, 3'b000, 1'b1, 18'd0,     3'b100};
        tbl[16] = '{1'b1, 3'b001, 3'b111, 18'd38401, 16'h0011, 3'b001, 1'b1, A0,        3'b000};

        Resetn = 1'b0;
        req = '0;
        req_we_n = '1;
        req_address = '0;
        req_write_data = '0;
        SRAM_read_data = '0;
        @(negedge Clock);
        tick();

        // vector table: reset, rotation 001 -> 010 -> 100 -> 001, read tagging, non-owner isolation
        for (int i = 0; i < 17; i++) begin
            Resetn = tbl[i].rst;
            req = tbl[i].rq;
            req_we_n = tbl[i].we;
            req_address = {A2, tbl[i].a1, A0};
            req_write_data = {WD2, WD1, WD0};
            SRAM_read_data = tbl[i].rd;
            #1;
            exp_wd = (tbl[i].g == 3'b001) ? WD0 : (tbl[i].g == 3'b010) ? WD1 : (tbl[i].g == 3'b100) ? WD2 : '0;
            chk($sformatf("vec%0d_grant", i), 64'(grant), 64'(tbl[i].g));
            chk($sformatf("vec%0d_we_n", i), 64'(SRAM_we_n), 64'(tbl[i].swe));
            chk($sformatf("vec%0d_addr", i), 64'(SRAM_address), 64'(tbl[i].sa));
            chk($sformatf("vec%0d_wdata", i), 64'(SRAM_write_data), 64'(exp_wd));
            chk($sformatf("vec%0d_rvalid", i), 64'(rdata_valid), 64'(tbl[i].rv));
            chk($sformatf("vec%0d_rdata", i), 64'(rdata), 64'(tbl[i].rd));
            tick();
        end

        // reset while M2 owns with reads in flight
        Resetn = 1'b0;
        req = '0;
        req_we_n = '1;
        tick();
        Resetn = 1'b1;
        req = 3'b100;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            if (grant == 3'b100) found = 1'b1;
            else tick();
        end
        chk("rst_flight_m2_granted", 64'(found), 64'(1));
        tick();
        Resetn = 1'b0;
        tick();
        #1;
        chk("rst_flight_grant", 64'(grant), 64'(0));
        chk("rst_flight_rvalid0", 64'(rdata_valid), 64'(0));
        Resetn = 1'b1;
        req = 3'b111;
        #1;
        chk("rst_flight_rvalid1", 64'(rdata_valid), 64'(0));
        chk("rst_flight_idle_we_n", 64'(SRAM_we_n), 64'(1));
        chk("rst_flight_idle_addr", 64'(SRAM_address), 64'(0));
        tick();
        chk("rst_release_grant", 64'(grant), 64'(3'b001));

`ifdef SRAM_ARB_TIMEOUT_EN
        Resetn = 1'b0;
        req = '0;
        tick();
        Resetn = 1'b1;
        req = 3'b001;
        tick();
        req = 3'b011;
        for (int k = 1; k <= MAX_HOLD; k++) begin
            #1;
            chk($sformatf("timeout_pulse_c%0d", k), 64'(timeout_pulse), 64'(k == MAX_HOLD));
            chk($sformatf("timeout_grant_c%0d", k), 64'(grant), 64'(3'b001));
            tick();
        end
        chk("timeout_handoff_grant", 64'(grant), 64'(0));
        tick();
        chk("timeout_idle_grant", 64'(grant), 64'(0));
        tick();
        chk("timeout_new_owner", 64'(grant), 64'(3'b010));
`endif

        // randomized run against the reference model
        Resetn = 1'b0;
        req = '0;
        tick();
        m_owner = -1;
        m_ptr = 0;
        m_held = 0;
        m_dead = 1'b0;
        cyc = 0;
        foreach (due[k]) due[k] = -1;

        for (int c = 0; c < NRAND; c++) begin
            Resetn = ($urandom_range(149) != 0);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(5) == 0) req[k] = ~req[k];
                req_address[k*AW +: AW] = AW'($urandom);
                req_write_data[k*DW +: DW] = DW'($urandom);
            end
            req_we_n = N'($urandom);
            SRAM_read_data = DW'($urandom);
            #1;
            exp_g  = '0;
            exp_a  = '0;
            exp_wd = '0;
            exp_we = 1'b1;
            exp_to = 1'b0;
            if (m_owner >= 0) begin
                exp_g  = N'(1 << m_owner);
                exp_a  = req_address[m_owner*AW +: AW];
                exp_wd = req_write_data[m_owner*DW +: DW];
                exp_we = req_we_n[m_owner];
`ifdef SRAM_ARB_TIMEOUT_EN
                exp_to = (m_held >= MAX_HOLD) && ((req & ~exp_g) != '0);
`endif
            end
            exp_rv = (due[cyc] >= 0) ? N'(1 << due[cyc]) : '0;
            chk("rand_grant", 64'(grant), 64'(exp_g));
            chk("rand_addr", 64'(SRAM_address), 64'(exp_a));
            chk("rand_wdata", 64'(SRAM_write_data), 64'(exp_wd));
            chk("rand_we_n", 64'(SRAM_we_n), 64'(exp_we));
            chk("rand_rvalid", 64'(rdata_valid), 64'(exp_rv));
            chk("rand_rdata", 64'(rdata), 64'(SRAM_read_data));
`ifdef SRAM_ARB_TIMEOUT_EN
            chk("rand_timeout", 64'(timeout_pulse), 64'(exp_to));
`endif
            if (!Resetn) begin
                m_owner = -1;
                m_ptr = 0;
                m_dead = 1'b0;
                for (int k = 1; k <= LAT; k++) due[cyc+k] = -1;
            end else if (m_owner >= 0) begin
                if (req_we_n[m_owner]) due[cyc+LAT] = m_owner;
                if (!req[m_owner] || exp_to) begin
                    m_ptr = (m_owner + 1) % N;
                    m_owner = -1;
                    m_dead = 1'b1;
                end else begin
                    m_held++;
                end
            end else if (m_dead) begin
                m_dead = 1'b0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && req[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                        m_held = 1;
                    end
                end
            end
            tick();
            cyc++;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
